// File: rtl/qarma64_round_sequencer.sv
// Iterative QARMA-64 round controller: one forward Round, one backward iRound, 64-bit state register.
// Latency: 2*ROUNDS+2 cycles from the accept edge to out_valid; one block per 2*ROUNDS+4 cycles at best.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready; abort flushes to IDLE.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     64-bit whitened input block on in_data
//   abort                 synchronous flush of the block in flight
//   rk_idx / rk           step index to the key schedule, tweakey returned combinationally
//   out_valid/out_ready   64-bit result on out_data (the state register, qualified by out_valid)
//   busy                  high in every state except IDLE
module qarma64_round_sequencer #(
  parameter int ROUNDS = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        abort,
  output logic [3:0]  rk_idx,
  input  logic [63:0] rk,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_FWD, S_C0, S_C1, S_BWD, S_DONE} fsm_t;
  typedef logic [15:0][3:0] cells_t;  // cell i of the 4x4 state lives at [15-i]

  localparam logic [3:0] LAST_FWD  = 4'(ROUNDS - 1);
  localparam logic [3:0] IDX_C0    = 4'(ROUNDS);
  localparam logic [3:0] IDX_C1    = 4'(ROUNDS + 1);
  localparam logic [3:0] FIRST_BWD = 4'(ROUNDS + 2);
  localparam logic [3:0] LAST_BWD  = 4'(2 * ROUNDS + 1);

  // sigma1 S-box; it is an involution, so the backward round reuses it.
  localparam logic [3:0] SBOX [16] = '{4'hA, 4'hD, 4'hE, 4'h6, 4'hF, 4'h7, 4'h3, 4'h5,
                                       4'h9, 4'h8, 4'h0, 4'hC, 4'hB, 4'h1, 4'h2, 4'h4};
  // Cell shuffle: new[i] = old[TAU[i]]; TAU_INV undoes it.
  localparam int TAU     [16] = '{0, 11, 6, 13, 10, 1, 12, 7, 5, 14, 3, 8, 15, 4, 9, 2};
  localparam int TAU_INV [16] = '{0, 5, 15, 10, 13, 8, 2, 7, 11, 14, 4, 1, 6, 3, 9, 12};

  function automatic logic [3:0] rho1(input logic [3:0] x);
    return {x[2:0], x[3]};
  endfunction

  function automatic logic [3:0] rho2(input logic [3:0] x);
    return {x[1:0], x[3:2]};
  endfunction

  function automatic logic [63:0] shuffle(input logic [63:0] s, input logic inv);
    cells_t a, r;
    a = s;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[15 - i] = inv ? a[15 - TAU_INV[i]] : a[15 - TAU[i]];
    end
    return r;
  endfunction

  // Column mix with circ(0, rho, rho^2, rho); involutory, shared by both directions.
  function automatic logic [63:0] mix(input logic [63:0] s);
    cells_t a, r;
    a = s;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        r[15 - (4 * row + col)] = rho1(a[15 - (4 * ((row + 1) % 4) + col)])
                                ^ rho2(a[15 - (4 * ((row + 2) % 4) + col)])
                                ^ rho1(a[15 - (4 * ((row + 3) % 4) + col)]);
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] sub(input logic [63:0] s);
    cells_t a, r;
    a = s;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[i] = SBOX[a[i]];
    end
    return r;
  endfunction

  function automatic logic [63:0] round_fwd(input logic [63:0] tk, input logic [63:0] s);
    return sub(mix(shuffle(s ^ tk, 1'b0)));
  endfunction

  function automatic logic [63:0] round_bwd(input logic [63:0] tk, input logic [63:0] s);
    return shuffle(mix(sub(s)), 1'b1) ^ tk;
  endfunction

  fsm_t        fsm, fsm_n;
  logic [3:0]  step, step_n;
  logic [63:0] st, st_n;
  logic        rdy_en;  // holds in_ready low until the first edge after reset release
  logic [63:0] fwd_res, bwd_res;

  assign fwd_res = round_fwd(rk, st);
  assign bwd_res = round_bwd(rk, st);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm    <= S_IDLE;
      step   <= '0;
      st     <= '0;
      rdy_en <= 1'b0;
    end else begin
      fsm    <= fsm_n;
      step   <= step_n;
      st     <= st_n;
      rdy_en <= 1'b1;
    end
  end

  always_comb begin
    fsm_n     = fsm;
    step_n    = step;
    st_n      = st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (fsm != S_IDLE);
    rk_idx    = '0;
    out_data  = st;

    case (fsm)
      S_IDLE: begin
        in_ready = rdy_en;
        if (in_valid && rdy_en) begin
          st_n   = in_data;
          step_n = '0;
          fsm_n  = S_FWD;
        end
      end
      S_FWD: begin
        rk_idx = step;
        st_n   = fwd_res;
        step_n = step + 4'd1;
        if (step == LAST_FWD) fsm_n = S_C0;
      end
      S_C0: begin
        rk_idx = IDX_C0;
        st_n   = fwd_res;
        fsm_n  = S_C1;
      end
      S_C1: begin
        rk_idx = IDX_C1;
        st_n   = bwd_res;
        step_n = FIRST_BWD;
        fsm_n  = S_BWD;
      end
      S_BWD: begin
        rk_idx = step;
        st_n   = bwd_res;
        step_n = step + 4'd1;
        if (step == LAST_BWD) fsm_n = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_n = S_IDLE;
      end
      default: fsm_n = S_IDLE;
    endcase

    // Abort wins over step advance and the output handshake; the state register is left as is.
    if (abort && fsm != S_IDLE) begin
      fsm_n  = S_IDLE;
      step_n = '0;
      st_n   = st;
    end
  end

endmodule

// File: tb/tb_qarma64_round_sequencer.sv
`timescale 1ns/1ps
module tb_qarma64_round_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, abort, out_valid, out_ready, busy;
  logic [63:0] in_data, rk, out_data;
  logic [3:0]  rk_idx;
  logic        in_valid_b, in_ready_b, abort_b, out_valid_b, out_ready_b, busy_b;
  logic [63:0] in_data_b, rk_b, out_data_b;
  logic [3:0]  rk_idx_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ---------------- reference model ----------------
  localparam logic [3:0] SB [16] = '{4'hA, 4'hD, 4'hE, 4'h6, 4'hF, 4'h7, 4'h3, 4'h5,
                                     4'h9, 4'h8, 4'h0, 4'hC, 4'hB, 4'h1, 4'h2, 4'h4};
  localparam int TAU [16] = '{0, 11, 6, 13, 10, 1, 12, 7, 5, 14, 3, 8, 15, 4, 9, 2};
  localparam int COEF [4] = '{0, 1, 2, 1};

  function automatic logic [63:0] ks(input logic [3:0] idx);
    logic [63:0] c;
    int sh;
    c  = 64'h243F_6A88_85A3_08D3;
    sh = (int'(idx) * 5) % 64;
    c  = (c << sh) | (c >> (64 - sh));
    return c ^ {16{idx}};
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] x, input int n);
    logic [7:0] d;
    d = {x, x};
    return d[7 - n -: 4];
  endfunction

  function automatic logic [3:0] sinv(input logic [3:0] y);
    logic [3:0] r;
    r = '0;
    for (int v = 0; v < 16; v++) if (SB[v] == y) r = 4'(v);
    return r;
  endfunction

  function automatic logic [63:0] mcols(input logic [63:0] s);
    logic [15:0][3:0] a, o;
    a = s;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        for (int j = 1; j < 4; j++)
          o[15 - (4 * r + c)] ^= rotl(a[15 - (4 * ((r + j) % 4) + c)], COEF[j]);
    return o;
  endfunction

  function automatic logic [63:0] m_round(input logic [63:0] tk, input logic [63:0] s);
    logic [15:0][3:0] a, t;
    a = s ^ tk;
    for (int i = 0; i < 16; i++) t[15 - i] = a[15 - TAU[i]];
    a = mcols(t);
    for (int i = 0; i < 16; i++) t[15 - i] = SB[a[15 - i]];
    return t;
  endfunction

  function automatic logic [63:0] m_iround(input logic [63:0] tk, input logic [63:0] s);
    logic [15:0][3:0] a, t;
    a = s;
    for (int i = 0; i < 16; i++) t[15 - i] = sinv(a[15 - i]);
    a = mcols(t);
    for (int i = 0; i < 16; i++) t[15 - TAU[i]] = a[15 - i];
    return t ^ tk;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] din, input int r);
    logic [63:0] s;
    s = din;
    for (int i = 0; i < r; i++) s = m_round(ks(4'(i)), s);
    s = m_round(ks(4'(r)), s);
    s = m_iround(ks(4'(r + 1)), s);
    for (int i = r + 2; i <= 2 * r + 1; i++) s = m_iround(ks(4'(i)), s);
    return s;
  endfunction

  // ---------------- DUTs and key schedule ----------------
  assign rk   = ks(rk_idx);
  assign rk_b = ks(rk_idx_b);

  qarma64_round_sequencer #(.ROUNDS(7)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .abort(abort), .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  qarma64_round_sequencer #(.ROUNDS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .abort(abort_b), .rk_idx(rk_idx_b), .rk(rk_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .busy(busy_b)
  );

  // ---------------- scoreboard for the ROUNDS=7 instance ----------------
  logic [63:0] exp_q[$];
  int          lat_q[$];
  int          acc_edges[$];
  logic [3:0]  rk_log[$];
  logic        ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && !out_valid) rk_log.push_back(rk_idx);
      if (out_valid && !ov_prev) begin
        checks++;
        if (lat_q.size() == 0) begin
          errors++;
          $display("FAIL latency: out_valid rose with no block outstanding");
        end else if (cyc - lat_q[0] != 16) begin
          errors++;
          $display("FAIL latency: got %0d cycles, expected 16", cyc - lat_q[0]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result: unexpected output %h", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin
            errors++;
            $display("FAIL result: got %h, expected %h", out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, 7));
        lat_q.push_back(cyc + 1);
        acc_edges.push_back(cyc + 1);
      end
    end
    ov_prev = out_valid;
  end

  // ---------------- helpers ----------------
  task automatic send(input logic [63:0] d);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept: in_ready never rose for %h", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d results still outstanding after %0d cycles", exp_q.size(), budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    checks++; if (rk_idx !== 4'd0) begin errors++; $display("FAIL rst_rk_idx: got %0d, expected 0", rk_idx); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL rst_out_data: got %h, expected 0", out_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_golden();
    logic bad;
    out_ready = 1'b1;
    rk_log.delete();
    send(64'h0);
    wait_drain(40);
    checks++;
    if (rk_log.size() != 16) begin
      errors++;
      $display("FAIL golden_rk_count: got %0d indices, expected 16", rk_log.size());
    end else begin
      bad = 1'b0;
      for (int i = 0; i < 16; i++) if (rk_log[i] !== 4'(i)) bad = 1'b1;
      checks++;
      if (bad) begin errors++; $display("FAIL golden_rk_order: first idx %0d last idx %0d, expected 0..15", rk_log[0], rk_log[15]); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic bad;
    out_ready = 1'b0;
    @(posedge clk); #1;
    send(64'hDEAD_BEEF_0BAD_F00D);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!out_valid || exp_q.size() == 0) begin
      errors++;
      $display("FAIL bp_valid: out_valid=%b outstanding=%0d, expected 1 and 1", out_valid, exp_q.size());
    end else begin
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_data !== exp_q[0] || in_ready !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin errors++; $display("FAIL bp_hold: out_valid=%b out_data=%h in_ready=%b, expected 1 %h 0", out_valid, out_data, in_ready, exp_q[0]); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: busy=%b out_valid=%b, expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_abort();
    int n;
    logic rose;
    out_ready = 1'b1;
    send(64'h1357_9BDF_2468_ACE0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(busy && rk_idx == 4'd3) && n < 20);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    if (exp_q.size() != 0) begin void'(exp_q.pop_back()); void'(lat_q.pop_back()); end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_idle: busy=%b in_ready=%b, expected 0 1", busy, in_ready);
    end
    rose = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (out_valid) rose = 1'b1; end
    checks++;
    if (rose) begin errors++; $display("FAIL abort_no_output: out_valid rose=%b, expected 0", rose); end
    // abort while IDLE must not block the accept in the same cycle
    @(posedge clk); #1;
    abort = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF);
    abort = 1'b0;
    wait_drain(40);
  endtask

  task automatic test_back_to_back();
    logic [63:0] d [4] = '{64'h0123_4567_89AB_CDEF, 64'hA5A5_5A5A_F0F0_0F0F, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE};
    int n;
    out_ready = 1'b1;
    @(posedge clk); #1;
    acc_edges.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = d[i];
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 40);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain(60);
    checks++;
    if (acc_edges.size() != 4) begin
      errors++; $display("FAIL b2b_count: got %0d accepts, expected 4", acc_edges.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (acc_edges[i] - acc_edges[i - 1] != 18) begin
          errors++; $display("FAIL b2b_spacing: got %0d cycles, expected 18", acc_edges[i] - acc_edges[i - 1]);
        end
      end
    end
  endtask

  task automatic test_rounds1();
    logic [63:0] qb[$];
    logic [3:0]  lg[$];
    int acc, n;
    logic got, bad;
    out_ready_b = 1'b1;
    in_data_b   = 64'hC0FF_EE00_1234_5678;
    in_valid_b  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready_b && n < 20);
    qb.push_back(model(in_data_b, 1));
    acc = cyc + 1;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    got = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      @(negedge clk); n++;
      if (out_valid_b) got = 1'b1;
      else if (busy_b) lg.push_back(rk_idx_b);
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL r1_valid: out_valid never rose, expected 1");
    end else begin
      checks++;
      if (cyc - acc != 4) begin errors++; $display("FAIL r1_latency: got %0d cycles, expected 4", cyc - acc); end
      checks++;
      if (out_data_b !== qb[0]) begin errors++; $display("FAIL r1_result: got %h, expected %h", out_data_b, qb[0]); end
      void'(qb.pop_front());
    end
    bad = (lg.size() != 4);
    if (!bad) for (int i = 0; i < 4; i++) if (lg[i] !== 4'(i)) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL r1_rk_seq: got %0d indices, expected 0,1,2,3", lg.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    int n;
    out_ready = 1'b1;
    send(64'h5555_AAAA_3333_CCCC);
    n = 0;
    do begin @(negedge clk); n++; end while (!(busy && rk_idx >= 4'd10) && n < 30);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || rk_idx !== 4'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: out_valid=%b busy=%b rk_idx=%0d in_ready=%b, expected 0 0 0 0", out_valid, busy, rk_idx, in_ready);
    end
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midop_release: in_ready=%b busy=%b, expected 1 0", in_ready, busy);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; abort_b = 1'b0; out_ready_b = 1'b0;
    test_reset();
    test_golden();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_rounds1();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
